// File: rtl/fp_pkg.sv
// Shared FP encodings: unit-select constants, sequencer FSM states and default sizes.
// The decoder and the sequencer both import this so the unit numbering cannot drift.
package fp_pkg;

  localparam int FP_UNITS = 8;
  localparam int FP_SEL_W = 3;
  localparam int FP_TMO_W = 8;

  localparam logic [2:0] FPU_ADD    = 3'd0;
  localparam logic [2:0] FPU_MUL    = 3'd1;
  localparam logic [2:0] FPU_DIV    = 3'd2;
  localparam logic [2:0] FPU_MINMAX = 3'd3;
  localparam logic [2:0] FPU_CMP    = 3'd4;
  localparam logic [2:0] FPU_SGNJ   = 3'd5;
  localparam logic [2:0] FPU_CVT    = 3'd6;
  localparam logic [2:0] FPU_MV     = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fp_op_sequencer.sv
// Sequences one FP operation: latch decode, pulse the unit start, wait for done
// (with timeout), then issue a single-cycle FP or integer register-file write.
module fp_op_sequencer
  import fp_pkg::*;
#(
  parameter int UNITS = FP_UNITS,
  parameter int SEL_W = FP_SEL_W,
  parameter int TMO_W = FP_TMO_W
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_unit_sel,
  input  logic             in_wb_int,
  input  logic [4:0]       in_rd,
  input  logic [UNITS-1:0] in_done,
  output logic [UNITS-1:0] out_start,
  output logic [SEL_W-1:0] out_res_sel,
  output logic             out_wb_fp,
  output logic             out_wb_int,
  output logic [4:0]       out_wb_rd,
  output logic             out_stall,
  output logic             out_busy,
  output logic             out_err
);

  fsm_state_t       state_reg, state_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [UNITS-1:0] unit_oh_reg, unit_oh_next;
  logic [4:0]       rd_reg, rd_next;
  logic             wb_int_lat_reg, wb_int_lat_next;
  logic [TMO_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [UNITS-1:0] start_reg, start_next;
  logic             wb_fp_reg, wb_fp_next;
  logic             wb_int_reg, wb_int_next;
  logic             err_reg, err_next;
  logic             busy_reg;

  // One-hot decode of the incoming select; out-of-range selects decode to zero.
  logic [UNITS-1:0] sel_dec;
  genvar gi;
  generate
    for (gi = 0; gi < UNITS; gi++) begin : g_sel_dec
      assign sel_dec[gi] = (in_unit_sel == SEL_W'(gi));
    end
  endgenerate

  logic sel_ok;
  logic done_hit;
  assign sel_ok   = |sel_dec;
  assign done_hit = |(in_done & unit_oh_reg);
  assign cnt_inc  = cnt_reg + TMO_W'(1);

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    unit_oh_next    = unit_oh_reg;
    rd_next         = rd_reg;
    wb_int_lat_next = wb_int_lat_reg;
    cnt_next        = cnt_reg;
    start_next      = '0;
    wb_fp_next      = 1'b0;
    wb_int_next     = 1'b0;
    err_next        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (sel_ok) begin
            state_next      = ISSUE;
            sel_next        = in_unit_sel;
            unit_oh_next    = sel_dec;
            rd_next         = in_rd;
            wb_int_lat_next = in_wb_int;
            start_next      = sel_dec;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (done_hit) begin
          state_next  = WB;
          wb_int_next = wb_int_lat_reg;
          wb_fp_next  = ~wb_int_lat_reg;
        end else begin
          cnt_next = cnt_inc;
          // Fires on the (2**TMO_W - 1)th wait cycle without done.
          if (cnt_inc == '1) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_reg      <= IDLE;
      sel_reg        <= '0;
      unit_oh_reg    <= '0;
      rd_reg         <= '0;
      wb_int_lat_reg <= 1'b0;
      cnt_reg        <= '0;
      start_reg      <= '0;
      wb_fp_reg      <= 1'b0;
      wb_int_reg     <= 1'b0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      unit_oh_reg    <= unit_oh_next;
      rd_reg         <= rd_next;
      wb_int_lat_reg <= wb_int_lat_next;
      cnt_reg        <= cnt_next;
      start_reg      <= start_next;
      wb_fp_reg      <= wb_fp_next;
      wb_int_reg     <= wb_int_next;
      err_reg        <= err_next;
      busy_reg       <= (state_next != IDLE);
    end
  end

  // Stall is the only combinational output: it must cover the decode cycle itself.
  assign out_stall   = ((state_reg == IDLE) && in_valid && sel_ok) ||
                       (state_reg == ISSUE) || (state_reg == WAIT);
  assign out_start   = start_reg;
  assign out_res_sel = sel_reg;
  assign out_wb_rd   = rd_reg;
  assign out_wb_fp   = wb_fp_reg;
  assign out_wb_int  = wb_int_reg;
  assign out_busy    = busy_reg;
  assign out_err     = err_reg;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed + randomized bench for fp_op_sequencer; expected waveforms come from
// a per-operation timeline model (start/WB/timeout cycle numbers).
module tb_fp_op_sequencer;

  localparam int TB_TMO_W = 4;
  localparam int TMO_CYC  = (1 << TB_TMO_W) - 1;

  logic       in_clk = 1'b0;
  logic       in_rst;
  logic       in_valid;
  logic [2:0] in_unit_sel;
  logic       in_wb_int;
  logic [4:0] in_rd;
  logic [7:0] in_done;
  logic [7:0] out_start;
  logic [2:0] out_res_sel;
  logic       out_wb_fp;
  logic       out_wb_int;
  logic [4:0] out_wb_rd;
  logic       out_stall;
  logic       out_busy;
  logic       out_err;

  int tests = 0;
  int fails = 0;
  int prev_sel = 0;
  int prev_rd  = 0;

  always #5 in_clk = ~in_clk;

  fp_op_sequencer #(.UNITS(8), .SEL_W(3), .TMO_W(TB_TMO_W)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid),
    .in_unit_sel(in_unit_sel), .in_wb_int(in_wb_int), .in_rd(in_rd),
    .in_done(in_done), .out_start(out_start), .out_res_sel(out_res_sel),
    .out_wb_fp(out_wb_fp), .out_wb_int(out_wb_int), .out_wb_rd(out_wb_rd),
    .out_stall(out_stall), .out_busy(out_busy), .out_err(out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge in_clk);
    #1;
  endtask

  // One operation. d = cycles from start to done[sel] rising (0 = tied high);
  // glitch adds a one-cycle done[sel] pulse during the start cycle.
  task automatic run_op(input int sel, input bit wbi, input int rd, input int d, input bit glitch);
    int  eff;
    bit  tmo;
    int  wb_c;
    int  last;
    logic [7:0] dv;
    eff  = (d < 1) ? 1 : d;
    tmo  = (eff > TMO_CYC);
    wb_c = eff + 2;
    last = tmo ? (TMO_CYC + 2) : wb_c;
    for (int c = 0; c <= last; c++) begin
      if (c == 0) begin
        in_valid    = 1'b1;
        in_unit_sel = 3'(sel);
        in_wb_int   = wbi;
        in_rd       = 5'(rd);
      end else begin
        in_valid    = (tmo && c == last) ? 1'b0 : 1'($urandom);
        in_unit_sel = 3'($urandom);
        in_wb_int   = 1'($urandom);
        in_rd       = 5'($urandom);
      end
      dv = 8'($urandom);
      dv[sel] = (d == 0) || (c >= 1 + d) || (glitch && c == 1);
      in_done = dv;
      @(negedge in_clk);
      check("start", 32'(out_start), (c == 1) ? (32'd1 << sel) : 32'd0);
      check("busy", 32'(out_busy), 32'(c >= 1 && c <= (tmo ? TMO_CYC + 1 : wb_c)));
      check("stall", 32'(out_stall), 32'(c <= (tmo ? TMO_CYC + 1 : wb_c - 1)));
      check("wb_fp", 32'(out_wb_fp), 32'(!tmo && c == wb_c && !wbi));
      check("wb_int", 32'(out_wb_int), 32'(!tmo && c == wb_c && wbi));
      check("err", 32'(out_err), 32'(tmo && c == last));
      check("res_sel", 32'(out_res_sel), 32'((c == 0) ? prev_sel : sel));
      check("wb_rd", 32'(out_wb_rd), 32'((c == 0) ? prev_rd : rd));
      next_cycle();
    end
    prev_sel = sel;
    prev_rd  = rd;
    $display("[TB] op sel=%0d wb_int=%0d rd=%0d done_delay=%0d glitch=%0d -> %s at cycle %0d",
             sel, wbi, rd, d, glitch, tmo ? "timeout" : "writeback", last);
  endtask

  // Start an op whose unit never finishes, reset it in WAIT cycle k, check the abort.
  task automatic run_reset(input int sel, input int rd, input int k);
    for (int c = 0; c <= k; c++) begin
      in_valid    = (c == 0);
      in_unit_sel = 3'(sel);
      in_wb_int   = 1'b0;
      in_rd       = 5'(rd);
      in_done     = 8'($urandom);
      in_done[sel] = 1'b0;
      in_rst      = (c == k);
      @(negedge in_clk);
      check("rst_pre_busy", 32'(out_busy), 32'(c >= 1));
      next_cycle();
    end
    in_rst   = 1'b0;
    in_valid = 1'b0;
    in_done  = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge in_clk);
      check("rst_busy", 32'(out_busy), 32'd0);
      check("rst_stall", 32'(out_stall), 32'd0);
      check("rst_wb", 32'({out_wb_fp, out_wb_int}), 32'd0);
      check("rst_start", 32'(out_start), 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
      check("rst_rd", 32'(out_wb_rd), 32'd0);
      check("rst_sel", 32'(out_res_sel), 32'd0);
      next_cycle();
    end
    prev_sel = 0;
    prev_rd  = 0;
    $display("[TB] reset during WAIT cycle %0d of sel=%0d rd=%0d -> aborted", k, sel, rd);
  endtask

  initial begin
    in_rst      = 1'b1;
    in_valid    = 1'b0;
    in_unit_sel = '0;
    in_wb_int   = 1'b0;
    in_rd       = '0;
    in_done     = '0;
    repeat (3) next_cycle();
    in_rst = 1'b0;
    @(negedge in_clk);
    check("reset_outputs",
          32'({out_start, out_res_sel, out_wb_fp, out_wb_int, out_wb_rd, out_stall, out_busy, out_err}),
          32'd0);
    next_cycle();

    run_op(3, 1'b0, 5, 0, 1'b0);          // combinational unit
    run_op(2, 1'b1, 12, 10, 1'b0);        // divider, done 10 cycles after start
    run_op(1, 1'b0, 7, 100, 1'b0);        // never done: timeout
    run_op(1, 1'b0, 9, 6, 1'b1);          // distractors plus done pulse during ISSUE
    run_op(5, 1'b1, 31, TMO_CYC, 1'b0);   // done on the last allowed wait cycle
    run_op(6, 1'b0, 1, TMO_CYC + 1, 1'b0); // done one cycle too late
    run_reset(2, 17, 4);
    run_op(0, 1'b0, 3, 2, 1'b0);          // back-to-back pair
    run_op(4, 1'b1, 20, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(7, 0)), 1'($urandom), int'($urandom_range(31, 0)),
             int'($urandom_range(TMO_CYC + 2, 0)), 1'($urandom));
    end

    in_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
